// File: rtl/bp_pkg.sv
// Shared constants and counter-update helper for the branch predictor family.
package bp_pkg;

    localparam int BP_CTR_W = 2;
    localparam int BP_IDX_W = 6;
    localparam int BP_MISPRED_W = 16;

    // Next value of a ctr_w-bit saturating counter trained with one outcome.
    function automatic logic [31:0] sat_update(input logic [31:0] ctr,
                                               input logic        taken,
                                               input int unsigned ctr_w);
        logic [31:0] max_v;
        max_v = (32'd1 << ctr_w) - 32'd1;
        if (taken) begin
            if (ctr >= max_v) return max_v;
            else              return ctr + 32'd1;
        end else begin
            if (ctr == 32'd0) return 32'd0;
            else              return ctr - 32'd1;
        end
    endfunction

endpackage

// File: rtl/branch_predictor_table_if.sv
// Lookup / update / status bundle between fetch, resolution and the predictor table.
interface branch_predictor_table_if #(
    parameter int IDX_W = 6
);
    logic             lk_valid;
    logic [IDX_W-1:0] lk_pc;
    logic             pred_valid;
    logic             pred_taken;
    logic [IDX_W-1:0] pred_idx;
    logic             upd_valid;
    logic [IDX_W-1:0] upd_idx;
    logic             upd_taken;
    logic             upd_pred;
    logic [15:0]      mispred_cnt;

    modport master (
        output lk_valid, lk_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        input  pred_valid, pred_taken, pred_idx, mispred_cnt
    );

    modport slave (
        input  lk_valid, lk_pc, upd_valid, upd_idx, upd_taken, upd_pred,
        output pred_valid, pred_taken, pred_idx, mispred_cnt
    );
endinterface

// File: rtl/bp_sat_counter.sv
// One CTR_W-bit saturating direction counter; exposes the current and the
// would-be-trained MSB so the table can forward a same-cycle update.
module bp_sat_counter
    import bp_pkg::*;
#(
    parameter int CTR_W    = BP_CTR_W,
    parameter int CTR_INIT = 2 ** (CTR_W - 1)
) (
    input  logic clk,
    input  logic reset,
    input  logic i_upd_en,
    input  logic i_taken,
    output logic o_msb,
    output logic o_next_msb
);
    logic [CTR_W-1:0] r_ctr;
    logic [CTR_W-1:0] w_next;

    // Trained value for the resolved outcome.
    always_comb begin
        w_next = CTR_W'(sat_update(32'(r_ctr), i_taken, CTR_W));
    end

    // Counter state, trained only when addressed.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         r_ctr <= CTR_W'(CTR_INIT);
        else if (i_upd_en) r_ctr <= w_next;
    end

    assign o_msb      = r_ctr[CTR_W-1];
    assign o_next_msb = w_next[CTR_W-1];
endmodule

// File: rtl/branch_predictor_table.sv
// Table of saturating-counter predictors with optional gshare indexing,
// same-cycle update forwarding and a saturating misprediction counter.
module branch_predictor_table
    import bp_pkg::*;
#(
    parameter int CTR_W    = BP_CTR_W,
    parameter int IDX_W    = BP_IDX_W,
    parameter int HIST_W   = 0,
    parameter int CTR_INIT = 2 ** (CTR_W - 1)
) (
    input logic                     clk,
    input logic                     reset,
    branch_predictor_table_if.slave bus
);
    localparam int N_ENT = 2 ** IDX_W;

    logic             w_msb      [N_ENT];
    logic             w_next_msb [N_ENT];
    logic [IDX_W-1:0] w_lk_idx;
    logic             w_lk_taken;
    logic             r_pred_valid;
    logic             r_pred_taken;
    logic [IDX_W-1:0] r_pred_idx;
    logic [15:0]      r_mispred_cnt;

    for (genvar g = 0; g < N_ENT; g++) begin : g_ent
        bp_sat_counter #(
            .CTR_W    (CTR_W),
            .CTR_INIT (CTR_INIT)
        ) u_ctr (
            .clk        (clk),
            .reset      (reset),
            .i_upd_en   (bus.upd_valid && (bus.upd_idx == IDX_W'(g))),
            .i_taken    (bus.upd_taken),
            .o_msb      (w_msb[g]),
            .o_next_msb (w_next_msb[g])
        );
    end

    if (HIST_W > 0) begin : g_ghr
        logic [HIST_W-1:0] r_ghr;

        // Global history; the lookup hash sees the pre-shift value.
        always_ff @(posedge clk or posedge reset) begin
            if (reset)              r_ghr <= {HIST_W{1'b0}};
            else if (bus.upd_valid) r_ghr <= HIST_W'({r_ghr, bus.upd_taken});
        end

        assign w_lk_idx = bus.lk_pc ^ IDX_W'(r_ghr);
    end else begin : g_bimodal
        assign w_lk_idx = bus.lk_pc;
    end

    // Forward a same-cycle update so the lookup sees the trained counter.
    always_comb begin
        w_lk_taken = w_msb[w_lk_idx];
        if (bus.upd_valid && (bus.upd_idx == w_lk_idx)) begin
            w_lk_taken = w_next_msb[bus.upd_idx];
        end else begin
            w_lk_taken = w_msb[w_lk_idx];
        end
    end

    // Lookup response registers; direction and index hold across idle cycles.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_pred_valid <= 1'b0;
            r_pred_taken <= 1'b0;
            r_pred_idx   <= {IDX_W{1'b0}};
        end else begin
            r_pred_valid <= bus.lk_valid;
            if (bus.lk_valid) begin
                r_pred_taken <= w_lk_taken;
                r_pred_idx   <= w_lk_idx;
            end
        end
    end

    // Misprediction count, sticky at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mispred_cnt <= 16'h0000;
        end else if (bus.upd_valid && (bus.upd_pred != bus.upd_taken)
                     && (r_mispred_cnt != 16'hFFFF)) begin
            r_mispred_cnt <= r_mispred_cnt + 16'h0001;
        end
    end

    assign bus.pred_valid  = r_pred_valid;
    assign bus.pred_taken  = r_pred_taken;
    assign bus.pred_idx    = r_pred_idx;
    assign bus.mispred_cnt = r_mispred_cnt;
endmodule

// File: tb/tb_branch_predictor_table.sv
// Drives a bimodal and a gshare (HIST_W=4) table with identical traffic and
// compares both against an array-based model of the predictor rules.
module tb_branch_predictor_table;
    localparam int IW   = 6;
    localparam int NE   = 64;
    localparam int CMAX = 3;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    branch_predictor_table_if #(.IDX_W(IW)) bus_a();
    branch_predictor_table_if #(.IDX_W(IW)) bus_b();

    branch_predictor_table #(.CTR_W(2), .IDX_W(IW), .HIST_W(0), .CTR_INIT(2)) dut_a (
        .clk(clk), .reset(reset), .bus(bus_a));
    branch_predictor_table #(.CTR_W(2), .IDX_W(IW), .HIST_W(4), .CTR_INIT(2)) dut_b (
        .clk(clk), .reset(reset), .bus(bus_b));

    int n_chk = 0;
    int n_err = 0;

    int ctr_a [NE];
    int ctr_b [NE];
    int ghr, mis;
    int ev, et_a, ei_a, et_b, ei_b;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int sat(input int c, input bit t);
        if (t) return (c < CMAX) ? c + 1 : CMAX;
        return (c > 0) ? c - 1 : 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NE; i++) begin
            ctr_a[i] = 2;
            ctr_b[i] = 2;
        end
        ghr = 0; mis = 0;
        ev = 0; et_a = 0; ei_a = 0; et_b = 0; ei_b = 0;
    endtask

    task automatic drive(input bit lv, input int pc, input bit uv, input int ui,
                         input bit ut, input bit up);
        bus_a.lk_valid = lv; bus_a.lk_pc = IW'(pc);
        bus_a.upd_valid = uv; bus_a.upd_idx = IW'(ui);
        bus_a.upd_taken = ut; bus_a.upd_pred = up;
        bus_b.lk_valid = lv; bus_b.lk_pc = IW'(pc);
        bus_b.upd_valid = uv; bus_b.upd_idx = IW'(ui);
        bus_b.upd_taken = ut; bus_b.upd_pred = up;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "/a_valid"}, 32'(bus_a.pred_valid), ev);
        chk({tag, "/a_taken"}, 32'(bus_a.pred_taken), et_a);
        chk({tag, "/a_idx"},   32'(bus_a.pred_idx),   ei_a);
        chk({tag, "/a_mis"},   32'(bus_a.mispred_cnt), mis);
        chk({tag, "/b_valid"}, 32'(bus_b.pred_valid), ev);
        chk({tag, "/b_taken"}, 32'(bus_b.pred_taken), et_b);
        chk({tag, "/b_idx"},   32'(bus_b.pred_idx),   ei_b);
        chk({tag, "/b_mis"},   32'(bus_b.mispred_cnt), mis);
    endtask

    // One clock: drive, clock, advance the model, then optionally compare.
    task automatic step(input string tag, input bit lv, input int pc, input bit uv,
                        input int ui, input bit ut, input bit up, input bit do_chk);
        int idx_b;
        drive(lv, pc, uv, ui, ut, up);
        @(posedge clk);
        idx_b = pc ^ ghr;
        if (uv) begin
            ctr_a[ui] = sat(ctr_a[ui], ut);
            ctr_b[ui] = sat(ctr_b[ui], ut);
            if (ut != up && mis < 65535) mis++;
            ghr = ((ghr << 1) | int'(ut)) & 15;
        end
        ev = int'(lv);
        if (lv) begin
            et_a = (ctr_a[pc] >= 2) ? 1 : 0;
            ei_a = pc;
            et_b = (ctr_b[idx_b] >= 2) ? 1 : 0;
            ei_b = idx_b;
        end
        #1;
        if (do_chk) check_outputs(tag);
    endtask

    // Reset pulse placed between clock edges.
    task automatic async_reset(input string tag);
        #2 reset = 1'b1;
        #1;
        model_reset();
        check_outputs(tag);
        #2 reset = 1'b0;
    endtask

    initial begin
        int pc, ui, sel;
        bit lv, uv, ut, up;

        reset = 1'b1;
        drive(1'b0, 0, 1'b0, 0, 1'b0, 1'b0);
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_outputs("reset");
        #1 reset = 1'b0;

        step("first_lookup", 1'b1, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("first_lookup_taken", 32'(bus_a.pred_taken), 32'd1);
        chk("first_lookup_idx",   32'(bus_a.pred_idx),   32'd5);

        repeat (4) step("train_up", 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b1);
        repeat (2) step("train_dn", 1'b0, 0, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        step("after_dn", 1'b1, 5, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("sat_hi_then_dn_taken", 32'(bus_a.pred_taken), 32'd0);

        step("fwd", 1'b1, 5, 1'b1, 5, 1'b1, 1'b0, 1'b1);
        chk("fwd_taken", 32'(bus_a.pred_taken), 32'd1);

        repeat (4) step("drain", 1'b0, 0, 1'b1, 5, 1'b0, 1'b0, 1'b1);
        step("lo_up1", 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b1);
        chk("sat_lo_up1_taken", 32'(bus_a.pred_taken), 32'd0);
        step("lo_up2", 1'b1, 5, 1'b1, 5, 1'b1, 1'b1, 1'b1);
        chk("sat_lo_up2_taken", 32'(bus_a.pred_taken), 32'd1);

        async_reset("reset2");
        step("gh1", 1'b0, 0, 1'b1, 10, 1'b1, 1'b1, 1'b1);
        step("gh2", 1'b0, 0, 1'b1, 11, 1'b0, 1'b0, 1'b1);
        step("gh_lookup", 1'b1, 3, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("gshare_idx", 32'(bus_b.pred_idx), 32'h01);
        repeat (3) step("mis", 1'b0, 0, 1'b1, 20, 1'b1, 1'b0, 1'b1);
        chk("mispred_3", 32'(bus_a.mispred_cnt), 32'd3);

        for (int i = 0; i < 400; i++) begin
            lv  = 1'($urandom_range(0, 1));
            uv  = 1'($urandom_range(0, 1));
            ut  = 1'($urandom_range(0, 1));
            up  = 1'($urandom_range(0, 1));
            pc  = int'($urandom_range(0, NE - 1));
            sel = int'($urandom_range(0, 3));
            if (sel == 0)      ui = pc;
            else if (sel == 1) ui = pc ^ ghr;
            else               ui = int'($urandom_range(0, NE - 1));
            step("rand", lv, pc, uv, ui, ut, up, 1'b1);
        end

        for (int i = 0; i < 65540; i++) begin
            ut = 1'($urandom_range(0, 1));
            step("mis_flood", 1'b0, 0, 1'b1, int'($urandom_range(0, NE - 1)), ut, ~ut, 1'b0);
        end
        step("mis_sat", 1'b0, 0, 1'b0, 0, 1'b0, 1'b0, 1'b1);
        chk("mispred_sat", 32'(bus_a.mispred_cnt), 32'h0000FFFF);

        async_reset("reset_mid");
        for (int p = 0; p < NE; p++) begin
            step("post_reset", 1'b1, p, 1'b0, 0, 1'b0, 1'b0, 1'b1);
            chk("post_reset_taken_b", 32'(bus_b.pred_taken), 32'd1);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
